execute_stage: RTL and testbench

//   EX stage of the five-stage RV32I pipeline. Owns the ID/EX register.

---
 rtl/riscv_pkg.sv | 51 +++++
 rtl/alu.sv | 36 +++
 rtl/branch_compare.sv | 33 +++
 rtl/execute_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_execute_stage.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the execute stage: opcodes, ALU control codes, branch funct3 codes.
// Also holds the helper that derives the 4-bit ALU control from an instruction's opcode/funct fields.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Encoded as {funct7[5], funct3} so OP instructions map straight through.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_funct3_e;

    // OP-IMM only honours funct7[5] for shifts; its other immediates carry arbitrary bit 10.
    function automatic alu_op_e alu_ctrl_of(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic       funct7b5);
        alu_op_e ctrl;
        ctrl = ALU_ADD;
        if (opcode == OPC_OP)
            ctrl = alu_op_e'({funct7b5, funct3});
        else if (opcode == OPC_OP_IMM)
            ctrl = alu_op_e'({(funct3 == 3'b101) ? funct7b5 : 1'b0, funct3});
        return ctrl;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU, selected by the {funct7[5], funct3} control code.
// Undefined control codes fall back to addition.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_e         ctrl_i,
    output logic [XLEN-1:0] result_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        result_o = a_i + b_i;
        case (ctrl_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/branch_compare.sv
// Combinational branch condition evaluation for the six RV32I conditional branches.
// Reserved funct3 encodings never take.
module branch_compare
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      funct3_i,
    output logic            taken_o
);

    logic eq, lt_s, lt_u;

    assign eq   = (a_i == b_i);
    assign lt_s = ($signed(a_i) < $signed(b_i));
    assign lt_u = (a_i < b_i);

    always_comb begin
        taken_o = 1'b0;
        case (br_funct3_e'(funct3_i))
            BR_EQ:   taken_o = eq;
            BR_NE:   taken_o = !eq;
            BR_LT:   taken_o = lt_s;
            BR_GE:   taken_o = !lt_s;
            BR_LTU:  taken_o = lt_u;
            BR_GEU:  taken_o = !lt_u;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// EX stage of the five-stage RV32I pipeline: ID/EX register, operand forwarding, ALU,
// branch/jump resolution with fetch redirect, and the EX/MEM register feeding the memory stage.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    input  logic            mem_fwd_en,
    input  logic [4:0]      mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_en,
    input  logic [4:0]      wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            exm_valid,
    output logic [XLEN-1:0] exm_pc,
    output logic [XLEN-1:0] exm_alu_out,
    output logic [XLEN-1:0] exm_store_data,
    output logic [4:0]      exm_rd,
    output logic [2:0]      exm_funct3,
    output logic [6:0]      exm_opcode
);

    // ID/EX register
    logic            idex_valid_q, idex_valid_d;
    logic [XLEN-1:0] idex_pc_q, idex_pc_d;
    logic [XLEN-1:0] idex_rs1_data_q, idex_rs1_data_d;
    logic [XLEN-1:0] idex_rs2_data_q, idex_rs2_data_d;
    logic [XLEN-1:0] idex_imm_q, idex_imm_d;
    logic [4:0]      idex_rs1_q, idex_rs1_d;
    logic [4:0]      idex_rs2_q, idex_rs2_d;
    logic [4:0]      idex_rd_q, idex_rd_d;
    logic [6:0]      idex_opcode_q, idex_opcode_d;
    logic [2:0]      idex_funct3_q, idex_funct3_d;
    logic            idex_f7b5_q, idex_f7b5_d;

    // EX/MEM register
    logic            exm_valid_q, exm_valid_d;
    logic [XLEN-1:0] exm_pc_q, exm_pc_d;
    logic [XLEN-1:0] exm_alu_out_q, exm_alu_out_d;
    logic [XLEN-1:0] exm_store_data_q, exm_store_data_d;
    logic [4:0]      exm_rd_q, exm_rd_d;
    logic [2:0]      exm_funct3_q, exm_funct3_d;
    logic [6:0]      exm_opcode_q, exm_opcode_d;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_result;
    logic [XLEN-1:0] pc_plus_imm, jalr_sum;
    alu_op_e         alu_ctrl;
    logic            br_taken, is_branch, is_jal, is_jalr;

    function automatic logic [XLEN-1:0] fwd_pick(input logic [4:0]      rs,
                                                 input logic [XLEN-1:0] rf_data,
                                                 input logic            m_en,
                                                 input logic [4:0]      m_rd,
                                                 input logic [XLEN-1:0] m_data,
                                                 input logic            w_en,
                                                 input logic [4:0]      w_rd,
                                                 input logic [XLEN-1:0] w_data);
        logic [XLEN-1:0] v;
        v = rf_data;
        if (rs != 5'd0 && m_en && m_rd == rs)
            v = m_data;
        else if (rs != 5'd0 && w_en && w_rd == rs)
            v = w_data;
        return v;
    endfunction

    assign rs1_fwd = fwd_pick(idex_rs1_q, idex_rs1_data_q, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                              wb_fwd_en, wb_fwd_rd, wb_fwd_data);
    assign rs2_fwd = fwd_pick(idex_rs2_q, idex_rs2_data_q, mem_fwd_en, mem_fwd_rd, mem_fwd_data,
                              wb_fwd_en, wb_fwd_rd, wb_fwd_data);

    assign is_branch = (idex_opcode_q == OPC_BRANCH);
    assign is_jal    = (idex_opcode_q == OPC_JAL);
    assign is_jalr   = (idex_opcode_q == OPC_JALR);

    always_comb begin
        op_a = rs1_fwd;
        case (idex_opcode_q)
            OPC_LUI:                        op_a = '0;
            OPC_AUIPC, OPC_JAL, OPC_BRANCH: op_a = idex_pc_q;
            default:                        op_a = rs1_fwd;
        endcase
    end

    assign op_b     = (idex_opcode_q == OPC_OP || is_branch) ? rs2_fwd : idex_imm_q;
    assign alu_ctrl = alu_ctrl_of(idex_opcode_q, idex_funct3_q, idex_f7b5_q);

    alu #(.XLEN(XLEN)) u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .ctrl_i   (alu_ctrl),
        .result_o (alu_result)
    );

    branch_compare #(.XLEN(XLEN)) u_branch_compare (
        .a_i      (rs1_fwd),
        .b_i      (rs2_fwd),
        .funct3_i (idex_funct3_q),
        .taken_o  (br_taken)
    );

    // Dedicated adders keep the redirect path off the ALU result.
    assign pc_plus_imm    = idex_pc_q + idex_imm_q;
    assign jalr_sum       = rs1_fwd + idex_imm_q;
    assign redirect_valid = idex_valid_q && ((is_branch && br_taken) || is_jal || is_jalr);
    assign redirect_pc    = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_plus_imm;

    always_comb begin
        idex_valid_d    = idex_valid_q;
        idex_pc_d       = idex_pc_q;
        idex_rs1_data_d = idex_rs1_data_q;
        idex_rs2_data_d = idex_rs2_data_q;
        idex_imm_d      = idex_imm_q;
        idex_rs1_d      = idex_rs1_q;
        idex_rs2_d      = idex_rs2_q;
        idex_rd_d       = idex_rd_q;
        idex_opcode_d   = idex_opcode_q;
        idex_funct3_d   = idex_funct3_q;
        idex_f7b5_d     = idex_f7b5_q;
        if (!stall) begin
            // A taken redirect squashes whatever decode is presenting this cycle.
            idex_valid_d    = id_valid && !redirect_valid;
            idex_pc_d       = id_pc;
            idex_rs1_data_d = id_rs1_data;
            idex_rs2_data_d = id_rs2_data;
            idex_imm_d      = id_imm;
            idex_rs1_d      = id_rs1;
            idex_rs2_d      = id_rs2;
            idex_rd_d       = id_rd;
            idex_opcode_d   = id_opcode;
            idex_funct3_d   = id_funct3;
            idex_f7b5_d     = id_funct7b5;
        end
    end

    always_comb begin
        exm_valid_d      = exm_valid_q;
        exm_pc_d         = exm_pc_q;
        exm_alu_out_d    = exm_alu_out_q;
        exm_store_data_d = exm_store_data_q;
        exm_rd_d         = exm_rd_q;
        exm_funct3_d     = exm_funct3_q;
        exm_opcode_d     = exm_opcode_q;
        if (!stall) begin
            exm_valid_d      = idex_valid_q;
            exm_pc_d         = idex_pc_q;
            exm_alu_out_d    = (is_jal || is_jalr) ? idex_pc_q + XLEN'(4) : alu_result;
            exm_store_data_d = rs2_fwd;
            exm_rd_d         = idex_rd_q;
            exm_funct3_d     = idex_funct3_q;
            exm_opcode_d     = idex_opcode_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idex_valid_q     <= 1'b0;
            idex_pc_q        <= RESET_PC;
            idex_rs1_data_q  <= '0;
            idex_rs2_data_q  <= '0;
            idex_imm_q       <= '0;
            idex_rs1_q       <= '0;
            idex_rs2_q       <= '0;
            idex_rd_q        <= '0;
            idex_opcode_q    <= '0;
            idex_funct3_q    <= '0;
            idex_f7b5_q      <= 1'b0;
            exm_valid_q      <= 1'b0;
            exm_pc_q         <= RESET_PC;
            exm_alu_out_q    <= '0;
            exm_store_data_q <= '0;
            exm_rd_q         <= '0;
            exm_funct3_q     <= '0;
            exm_opcode_q     <= '0;
        end else begin
            idex_valid_q     <= idex_valid_d;
            idex_pc_q        <= idex_pc_d;
            idex_rs1_data_q  <= idex_rs1_data_d;
            idex_rs2_data_q  <= idex_rs2_data_d;
            idex_imm_q       <= idex_imm_d;
            idex_rs1_q       <= idex_rs1_d;
            idex_rs2_q       <= idex_rs2_d;
            idex_rd_q        <= idex_rd_d;
            idex_opcode_q    <= idex_opcode_d;
            idex_funct3_q    <= idex_funct3_d;
            idex_f7b5_q      <= idex_f7b5_d;
            exm_valid_q      <= exm_valid_d;
            exm_pc_q         <= exm_pc_d;
            exm_alu_out_q    <= exm_alu_out_d;
            exm_store_data_q <= exm_store_data_d;
            exm_rd_q         <= exm_rd_d;
            exm_funct3_q     <= exm_funct3_d;
            exm_opcode_q     <= exm_opcode_d;
        end
    end

    assign exm_valid      = exm_valid_q;
    assign exm_pc         = exm_pc_q;
    assign exm_alu_out    = exm_alu_out_q;
    assign exm_store_data = exm_store_data_q;
    assign exm_rd         = exm_rd_q;
    assign exm_funct3     = exm_funct3_q;
    assign exm_opcode     = exm_opcode_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage: an instruction-level model predicts redirect and
// EX/MEM contents every cycle, and hand-computed literals pin the key scenarios.
module tb_execute_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0080;
    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
    } ins_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc, alu, st;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  op;
    } exm_t;

    logic        clock = 1'b0, reset = 1'b1, stall = 1'b0;
    logic        id_valid = 1'b0, id_funct7b5 = 1'b0;
    logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [6:0]  id_opcode = '0;
    logic [2:0]  id_funct3 = '0;
    logic        mem_fwd_en = 1'b0, wb_fwd_en = 1'b0;
    logic [4:0]  mem_fwd_rd = '0, wb_fwd_rd = '0;
    logic [31:0] mem_fwd_data = '0, wb_fwd_data = '0;
    logic        redirect_valid, exm_valid;
    logic [31:0] redirect_pc, exm_pc, exm_alu_out, exm_store_data;
    logic [4:0]  exm_rd;
    logic [2:0]  exm_funct3;
    logic [6:0]  exm_opcode;

    int errors = 0;
    int checks = 0;

    execute_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .stall(stall), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exm_valid(exm_valid), .exm_pc(exm_pc), .exm_alu_out(exm_alu_out),
        .exm_store_data(exm_store_data), .exm_rd(exm_rd), .exm_funct3(exm_funct3),
        .exm_opcode(exm_opcode)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    function automatic logic [31:0] fw(input logic [4:0] rs, input logic [31:0] d);
        if (rs != 0 && mem_fwd_en && mem_fwd_rd == rs) return mem_fwd_data;
        if (rs != 0 && wb_fwd_en && wb_fwd_rd == rs) return wb_fwd_data;
        return d;
    endfunction

    function automatic logic [31:0] rv_arith(input logic [2:0] f3, input logic alt,
                                             input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << y[4:0];
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic logic [31:0] m_result(input ins_t i);
        logic [31:0] a, b;
        a = fw(i.rs1, i.d1);
        b = fw(i.rs2, i.d2);
        case (i.op)
            LUI:       return i.imm;
            AUIPC:     return i.pc + i.imm;
            JAL, JALR: return i.pc + 32'd4;
            OP:        return rv_arith(i.f3, i.f7, a, b);
            OPI:       return rv_arith(i.f3, (i.f3 == 3'd5) && i.f7, a, i.imm);
            BR:        return i.pc + b;
            default:   return a + i.imm;
        endcase
    endfunction

    function automatic bit m_cond(input ins_t i);
        logic [31:0] a, b;
        a = fw(i.rs1, i.d1);
        b = fw(i.rs2, i.d2);
        case (i.f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_redir(input ins_t i);
        return i.v && (i.op == JAL || i.op == JALR || (i.op == BR && m_cond(i)));
    endfunction

    function automatic logic [31:0] m_target(input ins_t i);
        if (i.op == JALR) return (fw(i.rs1, i.d1) + i.imm) & 32'hFFFF_FFFE;
        return i.pc + i.imm;
    endfunction

    ins_t m_ex;
    exm_t m_exm;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ex = '0;
            m_exm = '0;
            m_exm.pc = RESET_PC;
        end else if (!stall) begin
            bit rv;
            rv = m_redir(m_ex);
            m_exm.v   = m_ex.v;
            m_exm.pc  = m_ex.pc;
            m_exm.alu = m_result(m_ex);
            m_exm.st  = fw(m_ex.rs2, m_ex.d2);
            m_exm.rd  = m_ex.rd;
            m_exm.f3  = m_ex.f3;
            m_exm.op  = m_ex.op;
            m_ex = '{v: id_valid && !rv, pc: id_pc, d1: id_rs1_data, d2: id_rs2_data,
                     imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, op: id_opcode,
                     f3: id_funct3, f7: id_funct7b5};
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir(m_ex)});
            if (m_redir(m_ex)) chk("redirect_pc", redirect_pc, m_target(m_ex));
            chk("exm_valid", {31'd0, exm_valid}, {31'd0, m_exm.v});
            if (m_exm.v) begin
                chk("exm_pc", exm_pc, m_exm.pc);
                chk("exm_alu_out", exm_alu_out, m_exm.alu);
                chk("exm_store_data", exm_store_data, m_exm.st);
                chk("exm_rd", {27'd0, exm_rd}, {27'd0, m_exm.rd});
                chk("exm_funct3", {29'd0, exm_funct3}, {29'd0, m_exm.f3});
                chk("exm_opcode", {25'd0, exm_opcode}, {25'd0, m_exm.op});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic ins_t mk(input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm);
        return '{v: 1'b1, pc: pc, d1: d1, d2: d2, imm: imm, rs1: rs1, rs2: rs2, rd: rd,
                 op: op, f3: f3, f7: f7};
    endfunction

    task automatic drv(input ins_t i);
        id_valid = i.v; id_pc = i.pc; id_rs1_data = i.d1; id_rs2_data = i.d2; id_imm = i.imm;
        id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; id_opcode = i.op;
        id_funct3 = i.f3; id_funct7b5 = i.f7;
    endtask

    task automatic idle();
        id_valid = 1'b0;
    endtask

    task automatic fwd_set(input logic me, input logic [4:0] mr, input logic [31:0] md,
                           input logic we, input logic [4:0] wr, input logic [31:0] wd);
        mem_fwd_en = me; mem_fwd_rd = mr; mem_fwd_data = md;
        wb_fwd_en = we; wb_fwd_rd = wr; wb_fwd_data = wd;
    endtask

    ins_t vec[14];
    logic [31:0] s_pc, s_alu;
    logic        s_v;
    int n400, n404;

    initial begin
        // Reset values
        step();
        step();
        chk("rst_exm_valid", {31'd0, exm_valid}, 32'd0);
        chk("rst_exm_pc", exm_pc, RESET_PC);
        chk("rst_exm_alu", exm_alu_out, 32'd0);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        reset = 1'b0;

        // ADD x3,x1,x2: x1 from MEM, x2 from WB
        drv(mk(32'h10, OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 32'd0));
        fwd_set(1'b1, 5'd1, 32'd5, 1'b1, 5'd2, 32'd7);
        step(); idle(); step();
        chk("add_fwd_mem_wb", exm_alu_out, 32'd12);

        // MEM and WB both match rs1: MEM wins
        drv(mk(32'h14, OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd7, 32'd0));
        fwd_set(1'b1, 5'd1, 32'd5, 1'b1, 5'd1, 32'd99);
        step(); idle(); step();
        chk("add_mem_priority", exm_alu_out, 32'd12);

        // x0 is never forwarded
        drv(mk(32'h18, OP, 3'd0, 1'b0, 5'd0, 5'd2, 5'd3, 32'd0, 32'd7, 32'd0));
        fwd_set(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        step(); idle(); step();
        chk("add_x0_noforward", exm_alu_out, 32'd7);
        fwd_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // BEQ taken flushes the following instruction
        drv(mk(32'h100, BR, 3'd0, 1'b0, 5'd3, 5'd4, 5'd0, 32'd9, 32'd9, 32'h20));
        step();
        chk("beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        drv(mk(32'h104, OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd6, 32'd1, 32'd1, 32'd0));
        step(); idle();
        chk("beq_in_exm", exm_pc, 32'h100);
        step();
        chk("beq_flush_bubble", {31'd0, exm_valid}, 32'd0);

        // JALR x1: target cleared of bit 0, link = pc+4
        drv(mk(32'h200, JALR, 3'd0, 1'b0, 5'd5, 5'd0, 5'd1, 32'h1003, 32'd0, 32'd4));
        step(); idle();
        chk("jalr_redirect_pc", redirect_pc, 32'h1006);
        step();
        chk("jalr_link", exm_alu_out, 32'h204);

        // Stall 3 cycles with a valid ADD in ID/EX and another in EX/MEM
        drv(mk(32'h3FC, OP, 3'd0, 1'b0, 5'd6, 5'd7, 5'd4, 32'd1, 32'd2, 32'd0));
        step();
        drv(mk(32'h400, OP, 3'd0, 1'b0, 5'd6, 5'd7, 5'd5, 32'd10, 32'd20, 32'd0));
        step();
        drv(mk(32'h404, OP, 3'd0, 1'b1, 5'd6, 5'd7, 5'd8, 32'd50, 32'd8, 32'd0));
        stall = 1'b1;
        s_v = exm_valid; s_pc = exm_pc; s_alu = exm_alu_out;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_valid", {31'd0, exm_valid}, {31'd0, s_v});
            chk("stall_hold_pc", exm_pc, s_pc);
            chk("stall_hold_alu", exm_alu_out, s_alu);
        end
        stall = 1'b0;
        n400 = 0; n404 = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 0) idle();
            if (exm_valid && exm_pc == 32'h400) n400++;
            if (exm_valid && exm_pc == 32'h404) n404++;
        end
        chk("stall_emerge_once_400", n400, 32'd1);
        chk("stall_emerge_once_404", n404, 32'd1);

        // Reset mid-stream clears EX/MEM before the next edge
        drv(mk(32'h500, OP, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd4, 32'd4, 32'd0));
        step(); idle(); step();
        chk("pre_reset_valid", {31'd0, exm_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_valid", {31'd0, exm_valid}, 32'd0);
        chk("async_reset_pc", exm_pc, RESET_PC);
        step();
        reset = 1'b0;

        // Back-to-back mixed instruction stream, some with WB forwarding on x9
        fwd_set(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h100);
        vec[0]  = mk(32'h600, LUI,   3'd0, 1'b0, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'h12345000);
        vec[1]  = mk(32'h604, AUIPC, 3'd0, 1'b0, 5'd0, 5'd0, 5'd10, 32'd0, 32'd0, 32'h1000);
        vec[2]  = mk(32'h608, OPI,   3'd0, 1'b1, 5'd1, 5'd0, 5'd11, 32'd5, 32'd0, 32'hFFFF_FFFD);
        vec[3]  = mk(32'h60C, OPI,   3'd5, 1'b1, 5'd1, 5'd0, 5'd11, 32'h8000_0000, 32'd0, 32'h404);
        vec[4]  = mk(32'h610, OPI,   3'd5, 1'b0, 5'd1, 5'd0, 5'd11, 32'h8000_0000, 32'd0, 32'd4);
        vec[5]  = mk(32'h614, OP,    3'd0, 1'b1, 5'd1, 5'd2, 5'd12, 32'd3, 32'd5, 32'd0);
        vec[6]  = mk(32'h618, OP,    3'd2, 1'b0, 5'd1, 5'd2, 5'd12, 32'hFFFF_FFFF, 32'd1, 32'd0);
        vec[7]  = mk(32'h61C, OP,    3'd3, 1'b0, 5'd1, 5'd2, 5'd12, 32'hFFFF_FFFF, 32'd1, 32'd0);
        vec[8]  = mk(32'h620, LD,    3'd2, 1'b0, 5'd1, 5'd0, 5'd13, 32'h1000, 32'd0, 32'hFFFF_FFFC);
        vec[9]  = mk(32'h624, ST,    3'd2, 1'b0, 5'd1, 5'd9, 5'd0, 32'h2000, 32'hCAFE, 32'd8);
        vec[10] = mk(32'h628, BR,    3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 32'd1, 32'd1, 32'h40);
        vec[11] = mk(32'h700, BR,    3'd6, 1'b0, 5'd1, 5'd2, 5'd0, 32'd1, 32'hFFFF_FFFF, 32'h10);
        vec[12] = mk(32'h704, OP,    3'd0, 1'b0, 5'd1, 5'd9, 5'd14, 32'd1, 32'd0, 32'd0);
        vec[13] = mk(32'hFFFF_FFF0, JAL, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h20);
        for (int i = 0; i < 14; i++) begin
            drv(vec[i]);
            step();
        end
        idle();
        chk("jal_wrap_target", redirect_pc, 32'h10);
        step();
        chk("jal_wrap_link", exm_alu_out, 32'hFFFF_FFF4);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
